// File: rtl/tankb_bus_pkg.sv
// Shared defaults, FSM encodings and region indices for the TankB CPU bus front end.
package tankb_bus_pkg;

  localparam int NUM_REGIONS_DEF = 4;
  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 8;
  localparam int WAIT_W_DEF      = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int RGN_ROM  = 0;
  localparam int RGN_RAM  = 1;
  localparam int RGN_VRAM = 2;
  localparam int RGN_IO   = 3;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tankb_region_decode.sv
// Combinational priority address decoder: lowest-index matching window wins.
module tankb_region_decode
  import tankb_bus_pkg::*;
#(
  parameter int NUM_REGIONS = NUM_REGIONS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SEL_W       = sel_width(NUM_REGIONS)
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [NUM_REGIONS*ADDR_W-1:0] base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] mask,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic [SEL_W-1:0]              sel,
  output logic                          any_hit
);

  always_comb begin
    cs      = '0;
    sel     = '0;
    any_hit = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!any_hit &&
          (((addr ^ base[i*ADDR_W +: ADDR_W]) & mask[i*ADDR_W +: ADDR_W]) == '0)) begin
        any_hit = 1'b1;
        sel     = SEL_W'(i);
        cs[i]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tankb_bus_decode.sv
// TankB 6502 bus front end: region decode, write strobes, registered read data, wait states.
// Build option TANKB_BUS_OPEN_BUS_EN: unmapped reads hold the last cpu_din (open-bus float).
module tankb_bus_decode
  import tankb_bus_pkg::*;
#(
  parameter int NUM_REGIONS = NUM_REGIONS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_W      = WAIT_W_DEF,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h1000, 16'h0800, 16'h0000, 16'h8000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hF000, 16'hF800, 16'hF800, 16'h8000},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {3'd2, 3'd0, 3'd0, 3'd0}
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          cpu_clken,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          we,
  input  logic [NUM_REGIONS*DATA_W-1:0] region_rdata,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic [NUM_REGIONS-1:0]        wr_en,
  output logic [DATA_W-1:0]             cpu_din,
  output logic                          ready
);

  localparam int SEL_W = sel_width(NUM_REGIONS);

  logic [NUM_REGIONS-1:0] dec_cs;
  logic [SEL_W-1:0]       dec_sel;
  logic                   dec_hit;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   cpu_din_q, cpu_din_d;

  logic [WAIT_W-1:0]      wait_sel;
  logic [DATA_W-1:0]      rdata_dec;
  logic [DATA_W-1:0]      rdata_lat;
  logic [NUM_REGIONS-1:0] cs_lat;

  tankb_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .SEL_W       (SEL_W)
  ) u_decode (
    .addr    (addr),
    .base    (REGION_BASE),
    .mask    (REGION_MASK),
    .cs      (dec_cs),
    .sel     (dec_sel),
    .any_hit (dec_hit)
  );

  assign wait_sel  = REGION_WAIT[dec_sel*WAIT_W +: WAIT_W];
  assign rdata_dec = region_rdata[dec_sel*DATA_W +: DATA_W];
  assign rdata_lat = region_rdata[sel_q*DATA_W +: DATA_W];

  always_comb begin
    cs_lat        = '0;
    cs_lat[sel_q] = 1'b1;
  end

  // While stalled the select stays on the region latched at entry; reset reverts to live decode.
  assign cs      = (state_q == ST_WAIT && !RESET) ? cs_lat : dec_cs;
  assign wr_en   = cs & {NUM_REGIONS{we & cpu_clken & ready_q}};
  assign cpu_din = cpu_din_q;
  assign ready   = ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    ready_d   = ready_q;
    cpu_din_d = cpu_din_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (!we) begin
          if (dec_hit) begin
            cpu_din_d = rdata_dec;
          end else begin
`ifdef TANKB_BUS_OPEN_BUS_EN
            cpu_din_d = cpu_din_q;
`else
            cpu_din_d = '0;
`endif
          end
        end
        if (cpu_clken && dec_hit && (wait_sel != '0)) begin
          cnt_d   = wait_sel;
          sel_d   = dec_sel;
          ready_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ready_d   = 1'b0;
        cpu_din_d = rdata_lat;
        cnt_d     = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      ready_q   <= 1'b1;
      cpu_din_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      ready_q   <= ready_d;
      cpu_din_q <= cpu_din_d;
    end
  end

endmodule

// File: tb/tb_tankb_bus_decode.sv
// Self-checking bench for tankb_bus_decode: vector table with a read-data/ready scoreboard.
module tb_tankb_bus_decode;

  logic        clk = 1'b0;
  logic        RESET;
  logic        cpu_clken;
  logic [15:0] addr;
  logic        we;
  logic [31:0] region_rdata;
  logic [3:0]  cs;
  logic [3:0]  wr_en;
  logic [7:0]  cpu_din;
  logic        ready;

  logic [15:0] addr2;
  logic [3:0]  cs2;
  logic [3:0]  wr_en2;
  logic [7:0]  cpu_din2;
  logic        ready2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tankb_bus_decode u_dut (
    .clk          (clk),
    .RESET        (RESET),
    .cpu_clken    (cpu_clken),
    .addr         (addr),
    .we           (we),
    .region_rdata (region_rdata),
    .cs           (cs),
    .wr_en        (wr_en),
    .cpu_din      (cpu_din),
    .ready        (ready)
  );

  // Regions 0 and 2 both cover 0x0000 here.
  tankb_bus_decode #(
    .REGION_BASE ({16'h1000, 16'h0000, 16'h0800, 16'h0000})
  ) u_ovl (
    .clk          (clk),
    .RESET        (RESET),
    .cpu_clken    (1'b0),
    .addr         (addr2),
    .we           (1'b0),
    .region_rdata (32'h0),
    .cs           (cs2),
    .wr_en        (wr_en2),
    .cpu_din      (cpu_din2),
    .ready        (ready2)
  );

  typedef struct {
    logic        rst;
    logic        clken;
    logic [15:0] addr;
    logic        we;
    logic [31:0] rdata;
    logic [3:0]  cs;
    logic [3:0]  wr;
    logic        rdy;
    logic [7:0]  din;
  } vec_t;

  typedef struct {
    int         idx;
    logic       rdy;
    logic [7:0] din;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec %0d got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    RESET        = v.rst;
    cpu_clken    = v.clken;
    addr         = v.addr;
    we           = v.we;
    region_rdata = v.rdata;
    #1;
    chk("cs", idx, 32'(cs), 32'(v.cs));
    chk("wr_en", idx, 32'(wr_en), 32'(v.wr));
    sb.push_back('{idx, v.rdy, v.din});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty vec %0d got 0 want 1", idx);
    end else begin
      e = sb.pop_front();
      chk("ready", e.idx, 32'(ready), 32'(e.rdy));
      chk("cpu_din", e.idx, 32'(cpu_din), 32'(e.din));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[16];
    logic [31:0] r0;
    logic [7:0]  ob;
    int          lo;
    bit          done;

    r0 = 32'h332211A9;
`ifdef TANKB_BUS_OPEN_BUS_EN
    ob = 8'h5A;
`else
    ob = 8'h00;
`endif
    //            rst   clken addr      we    rdata         cs     wr     rdy   din
    vecs[0]  = '{1'b1, 1'b0, 16'h4000, 1'b0, r0,           4'h0, 4'h0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 16'h8123, 1'b0, r0,           4'h1, 4'h0, 1'b1, 8'hA9};
    vecs[2]  = '{1'b0, 1'b0, 16'h8123, 1'b0, r0,           4'h1, 4'h0, 1'b1, 8'hA9};
    vecs[3]  = '{1'b0, 1'b1, 16'h0010, 1'b0, 32'h33225CA9, 4'h2, 4'h0, 1'b1, 8'h5C};
    vecs[4]  = '{1'b0, 1'b1, 16'h0810, 1'b1, r0,           4'h4, 4'h4, 1'b1, 8'h5C};
    vecs[5]  = '{1'b0, 1'b0, 16'h0810, 1'b1, r0,           4'h4, 4'h0, 1'b1, 8'h5C};
    vecs[6]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 32'h3322115A, 4'h1, 4'h0, 1'b1, 8'h5A};
    vecs[7]  = '{1'b0, 1'b1, 16'h4000, 1'b0, r0,           4'h0, 4'h0, 1'b1, ob};
    vecs[8]  = '{1'b0, 1'b1, 16'h1004, 1'b0, r0,           4'h8, 4'h0, 1'b0, 8'h33};
    vecs[9]  = '{1'b0, 1'b0, 16'h8000, 1'b0, 32'h442211A9, 4'h8, 4'h0, 1'b0, 8'h44};
    vecs[10] = '{1'b0, 1'b1, 16'h1000, 1'b1, 32'h552211A9, 4'h8, 4'h0, 1'b1, 8'h55};
    vecs[11] = '{1'b0, 1'b0, 16'h1000, 1'b1, r0,           4'h8, 4'h0, 1'b1, 8'h55};
    vecs[12] = '{1'b0, 1'b1, 16'h1004, 1'b0, 32'h662211A9, 4'h8, 4'h0, 1'b0, 8'h66};
    vecs[13] = '{1'b1, 1'b0, 16'h1004, 1'b0, r0,           4'h8, 4'h0, 1'b1, 8'h00};
    vecs[14] = '{1'b0, 1'b1, 16'h8123, 1'b0, r0,           4'h1, 4'h0, 1'b1, 8'hA9};
    vecs[15] = '{1'b0, 1'b1, 16'h0004, 1'b1, r0,           4'h2, 4'h2, 1'b1, 8'hA9};

    RESET        = 1'b1;
    cpu_clken    = 1'b0;
    addr         = 16'h4000;
    we           = 1'b0;
    region_rdata = r0;
    addr2        = 16'h0000;

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Stall length on a fresh IO access after the reset-aborted wait.
    @(negedge clk);
    cpu_clken = 1'b1;
    we        = 1'b0;
    addr      = 16'h1004;
    @(posedge clk);
    lo   = 0;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      cpu_clken = 1'b0;
      #1;
      if (ready == 1'b0) lo++;
      else done = 1'b1;
    end
    chk("ready_returned", 100, 32'(done), 32'd1);
    chk("stall_cycles", 100, 32'(lo), 32'd2);
    chk("wait_rdata", 100, 32'(cpu_din), 32'h33);

    @(negedge clk);
    addr2 = 16'h0000;
    #1;
    chk("overlap_cs_0000", 101, 32'(cs2), 32'h1);
    addr2 = 16'h0400;
    #1;
    chk("overlap_cs_0400", 102, 32'(cs2), 32'h1);
    addr2 = 16'h8000;
    #1;
    chk("overlap_cs_8000", 103, 32'(cs2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tankb_bus_decode.md
Name: tankb_bus_decode

Overview:
- Parametrised CPU bus front end for the TankB system.
- Sits between the 6502 core and its memory/IO devices, replacing the single hard-wired ROM chip-select and data mux.
- Decodes up to NUM_REGIONS address windows and drives one-hot chip selects and write strobes.
- Returns registered read data to the CPU and stretches cycles for slow devices via per-region wait states on a ready line.

Parameters:
- NUM_REGIONS, 4: number of decoded address windows.
- ADDR_W, 16: CPU address width.
- DATA_W, 8: CPU data width.
- WAIT_W, 3: width of a per-region wait-state count.
- REGION_BASE, {16'h1000,16'h0800,16'h0000,16'h8000}: packed NUM_REGIONS*ADDR_W bases; region i occupies slice i.
- REGION_MASK, {16'hF000,16'hF800,16'hF800,16'h8000}: packed masks; a 1 bit is compared, a 0 bit is ignored.
- REGION_WAIT, {3'd2,3'd0,3'd0,3'd0}: packed wait-state counts, in clk cycles.

Ports:
- clk  in  1  system clock; single domain.
- RESET  in  1  synchronous, active-high reset.
- cpu_clken  in  1  one-clk pulse marking the CPU bus-cycle strobe.
- addr  in  ADDR_W  CPU address.
- we  in  1  CPU write (1 = write).
- region_rdata  in  NUM_REGIONS*DATA_W  packed device read data; slice i belongs to region i.
- cs  out  NUM_REGIONS  one-hot chip selects.
- wr_en  out  NUM_REGIONS  one-clk write strobes.
- cpu_din  out  DATA_W  registered read data to the CPU.
- ready  out  1  CPU ready; 0 stalls the CPU.

Behaviour:
- Decode (combinational):
  - hit[i] = ((addr ^ BASE_i) & MASK_i) == 0.
  - cs = one-hot of the lowest-index hit; all zero if no hit.
  - Overlapping windows: lowest index wins.
- Write strobe: wr_en[i] = cs[i] & we & cpu_clken & ready. No strobe while stalled.
- FSM, states IDLE and WAIT:
  - IDLE: ready=1.
    - On cpu_clken with a hit on region i and WAIT_i>0: cnt<=WAIT_i, ready<=0, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT: ready=0; cnt decrements every clk. When cnt==1: ready<=1, go to IDLE.
  - ready is low for exactly WAIT_i clk cycles, starting the clk after the cpu_clken pulse.
  - In WAIT, changes on addr, we and cpu_clken are ignored. The region latched at entry (sel_q) selects read data.
- Read data:
  - cpu_din updates every clk.
  - In IDLE: takes region_rdata[sel] when there is a hit and we=0.
  - In WAIT: takes region_rdata[sel_q].
  - Gives one-clk latency, matching synchronous ROM/RAM.
  - During writes (we=1) cpu_din holds its value.
  - No hit with we=0: cpu_din <= 0 (base build).
- Reset (takes priority over everything, including mid-WAIT): state=IDLE, cnt=0, sel_q=0, ready=1, cpu_din=0. cs and wr_en follow the decode with ready=1.
- Width rules:
  - cnt is WAIT_W bits.
  - WAIT_i=0 means no stall.
  - No wrap: max stall is 2^WAIT_W-1.

Optional Feature:
- Macro: TANKB_BUS_OPEN_BUS_EN.
- Defined: an unmapped read (no hit, we=0) holds the last driven cpu_din value, emulating 6502 open-bus float.
- Undefined: an unmapped read returns all zeros.
- Reset clears cpu_din to 0 in both builds.

Decomposition:
- Package tankb_bus_pkg:
  - default NUM_REGIONS/ADDR_W/DATA_W/WAIT_W;
  - FSM state encodings ST_IDLE=1'b0, ST_WAIT=1'b1;
  - named region index constants RGN_ROM=0, RGN_RAM=1, RGN_VRAM=2, RGN_IO=3.
- One sub-module: tankb_region_decode, a pure combinational priority decoder.
  - In: addr, BASE, MASK.
  - Out: cs one-hot, sel index, any_hit.

Test Plan:
- Reset mid-wait: read 0x1004 (wait 2), assert RESET after 1 clk -> next clk ready=1, cpu_din=0x00, state IDLE. The next access behaves normally.
- ROM read, defaults: addr=0x8123, we=0, region_rdata[0]=0xA9, cpu_clken pulse -> cs=4'b0001, ready stays 1, cpu_din=0xA9 one clk later.
- IO wait state: addr=0x1004, we=0, cpu_clken -> cs=4'b1000, ready=0 for exactly 2 clks, then 1. cpu_din equals region_rdata[3] sampled during WAIT. An addr change mid-WAIT does not affect cs latch or data.
- Write strobe: addr=0x0810, we=1, cpu_clken -> wr_en=4'b0100 for one clk only. A write pulse to 0x1000 while ready=0 gives wr_en=0.
- Overlap priority: override REGION_BASE so regions 0 and 2 both hit 0x0000 -> cs=4'b0001 only.
- Unmapped read: read 0x8000 returning 0x5A, then read 0x4000 -> cpu_din=0x00 without the macro. With TANKB_BUS_OPEN_BUS_EN defined, cpu_din holds 0x5A.
